// File: rtl/wb_select_stage.sv
// Writeback select stage: picks one of NUM_SRC results and registers it for the register file.
// Optional operand-forward flags are built only when WB_FWD_EN is defined.
module wb_select_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] i_src,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic                      i_valid,
  input  logic                      i_wr_en,
  input  logic [RADDR_W-1:0]        i_rd,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [RADDR_W-1:0]        i_rs1,
  input  logic [RADDR_W-1:0]        i_rs2,
  output logic                      o_valid,
  output logic                      o_wr_en,
  output logic [RADDR_W-1:0]        o_rd,
  output logic [DATA_W-1:0]         o_wb_data,
  output logic                      o_sel_err,
  output logic [CNT_W-1:0]          o_retire_cnt,
  output logic                      o_fwd_rs1,
  output logic                      o_fwd_rs2
);

  logic [DATA_W-1:0]  w_sel_data;
  logic               w_legal;
  logic               w_load;
  logic               r_valid;
  logic               r_wr_en;
  logic [RADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]  r_wb_data;
  logic               r_sel_err;
  logic [CNT_W-1:0]   r_cnt;

  assign w_legal = (int'(i_sel) < NUM_SRC);
  assign w_load  = ~i_flush & ~i_stall;

  // Out-of-range selects resolve to zero rather than an undefined slice.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(i_sel) == k) begin
        w_sel_data = i_src[k*DATA_W +: DATA_W];
      end
    end
  end

  // Flush clears only the qualifiers; rd and data keep their last values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd      <= '0;
      r_wb_data <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_wr_en <= 1'b0;
    end else if (!i_stall) begin
      r_valid   <= i_valid;
      r_wr_en   <= i_valid & i_wr_en & (i_rd != '0) & w_legal;
      r_rd      <= i_rd;
      r_wb_data <= w_sel_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel_err <= 1'b0;
      r_cnt     <= '0;
    end else if (w_load && i_valid) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (!w_legal) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_wr_en      = r_wr_en;
  assign o_rd         = r_rd;
  assign o_wb_data    = r_wb_data;
  assign o_sel_err    = r_sel_err;
  assign o_retire_cnt = r_cnt;

`ifdef WB_FWD_EN
  assign o_fwd_rs1 = r_valid & r_wr_en & (r_rd == i_rs1) & (i_rs1 != '0);
  assign o_fwd_rs2 = r_valid & r_wr_en & (r_rd == i_rs2) & (i_rs2 != '0);
`else
  logic w_unused_rs;
  assign w_unused_rs = ^{i_rs1, i_rs2};
  assign o_fwd_rs1   = 1'b0;
  assign o_fwd_rs2   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: a default instance and a 3-source, 4-bit-counter instance.
module tb_wb_select_stage;

  typedef struct {
    logic        valid;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [31:0] cnt;
  } mdl_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] src;
  logic [1:0]   sel;
  logic         valid, wr_en, stall, flush;
  logic [4:0]   rd, rs1, rs2;

  logic        a_valid, a_wr_en, a_err, a_fwd1, a_fwd2;
  logic [4:0]  a_rd;
  logic [31:0] a_data, a_cnt;
  logic        b_valid, b_wr_en, b_err, b_fwd1, b_fwd2;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic [3:0]  b_cnt;

  int errors = 0;
  int checks = 0;
  mdl_t ma, mb;
  mdl_t qa[$];
  mdl_t qb[$];

  wb_select_stage u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_src(src), .i_sel(sel), .i_valid(valid),
    .i_wr_en(wr_en), .i_rd(rd), .i_stall(stall), .i_flush(flush), .i_rs1(rs1), .i_rs2(rs2),
    .o_valid(a_valid), .o_wr_en(a_wr_en), .o_rd(a_rd), .o_wb_data(a_data),
    .o_sel_err(a_err), .o_retire_cnt(a_cnt), .o_fwd_rs1(a_fwd1), .o_fwd_rs2(a_fwd2)
  );

  wb_select_stage #(.NUM_SRC(3), .CNT_W(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_src(src[95:0]), .i_sel(sel), .i_valid(valid),
    .i_wr_en(wr_en), .i_rd(rd), .i_stall(stall), .i_flush(flush), .i_rs1(rs1), .i_rs2(rs2),
    .o_valid(b_valid), .o_wr_en(b_wr_en), .o_rd(b_rd), .o_wb_data(b_data),
    .o_sel_err(b_err), .o_retire_cnt(b_cnt), .o_fwd_rs1(b_fwd1), .o_fwd_rs2(b_fwd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t mnext(input mdl_t m, input int nsrc, input int cntw);
    mdl_t n;
    logic legal;
    n = m;
    legal = (int'(sel) < nsrc);
    if (flush) begin
      n.valid = 1'b0;
      n.wr_en = 1'b0;
    end else if (!stall) begin
      n.valid = valid;
      n.rd    = rd;
      n.data  = legal ? src[int'(sel)*32 +: 32] : 32'h0;
      n.wr_en = valid & wr_en & (rd != 5'd0) & legal;
      if (valid) begin
        if (!legal) n.err = 1'b1;
        n.cnt = m.cnt + 32'd1;
        if (cntw < 32) n.cnt = n.cnt & ((32'd1 << cntw) - 32'd1);
      end
    end
    return n;
  endfunction

  function automatic mdl_t mzero();
    mdl_t z;
    z.valid = 1'b0; z.wr_en = 1'b0; z.rd = '0; z.data = '0; z.err = 1'b0; z.cnt = '0;
    return z;
  endfunction

  // Predict from the current inputs, push, clock, then pop and compare.
  task automatic step(input string tag);
    mdl_t ea, eb;
    ma = mnext(ma, 4, 32);
    mb = mnext(mb, 3, 4);
    qa.push_back(ma);
    qb.push_back(mb);
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk({tag, ".a.valid"}, 64'(a_valid), 64'(ea.valid));
    chk({tag, ".a.wr_en"}, 64'(a_wr_en), 64'(ea.wr_en));
    chk({tag, ".a.rd"},    64'(a_rd),    64'(ea.rd));
    chk({tag, ".a.data"},  64'(a_data),  64'(ea.data));
    chk({tag, ".a.err"},   64'(a_err),   64'(ea.err));
    chk({tag, ".a.cnt"},   64'(a_cnt),   64'(ea.cnt));
    chk({tag, ".b.valid"}, 64'(b_valid), 64'(eb.valid));
    chk({tag, ".b.wr_en"}, 64'(b_wr_en), 64'(eb.wr_en));
    chk({tag, ".b.data"},  64'(b_data),  64'(eb.data));
    chk({tag, ".b.err"},   64'(b_err),   64'(eb.err));
    chk({tag, ".b.cnt"},   64'(b_cnt),   64'(eb.cnt));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".a"}, {a_valid, a_wr_en, a_rd, a_data, a_err, a_cnt[20:0]}, 64'h0);
    chk({tag, ".b"}, {b_valid, b_wr_en, b_rd, b_data, b_err, b_cnt}, 64'h0);
  endtask

  task automatic chk_fwd(input string tag);
    logic ea1, ea2, eb1, eb2;
`ifdef WB_FWD_EN
    ea1 = ma.valid & ma.wr_en & (ma.rd == rs1) & (rs1 != 5'd0);
    ea2 = ma.valid & ma.wr_en & (ma.rd == rs2) & (rs2 != 5'd0);
    eb1 = mb.valid & mb.wr_en & (mb.rd == rs1) & (rs1 != 5'd0);
    eb2 = mb.valid & mb.wr_en & (mb.rd == rs2) & (rs2 != 5'd0);
`else
    ea1 = 1'b0; ea2 = 1'b0; eb1 = 1'b0; eb2 = 1'b0;
`endif
    chk({tag, ".a.fwd1"}, 64'(a_fwd1), 64'(ea1));
    chk({tag, ".a.fwd2"}, 64'(a_fwd2), 64'(ea2));
    chk({tag, ".b.fwd1"}, 64'(b_fwd1), 64'(eb1));
    chk({tag, ".b.fwd2"}, 64'(b_fwd2), 64'(eb2));
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    ma = mzero();
    mb = mzero();
    chk_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    src   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    sel = '0; valid = 1'b0; wr_en = 1'b0; stall = 1'b0; flush = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0;
    ma = mzero();
    mb = mzero();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Select sweep
    valid = 1'b1; wr_en = 1'b1; rd = 5'd5;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step("sweep");
      chk("sweep.data", 64'(a_data), 64'(32'hAAAA0000 + 32'h11110001 * s));
    end
    chk("sweep.cnt", 64'(a_cnt), 64'd4);
    chk("sweep.wr_en", 64'(a_wr_en), 64'd1);
    pulse_reset("rst_after_sweep");

    // x0 suppression
    rd = 5'd0; sel = 2'd1;
    step("x0");
    chk("x0.valid", 64'(a_valid), 64'd1);
    chk("x0.wr_en", 64'(a_wr_en), 64'd0);
    chk("x0.data", 64'(a_data), 64'hBBBB0001);

    // Stall holds, then flush beats stall
    rd = 5'd7; sel = 2'd1;
    step("load7");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd = 5'(10 + i); sel = 2'(i + 2); src[31:0] = 32'h1234_0000 + 32'(i);
      step("stall");
      chk("stall.rd", 64'(a_rd), 64'd7);
    end
    flush = 1'b1;
    step("flush");
    chk("flush.valid", 64'(a_valid), 64'd0);
    chk("flush.rd", 64'(a_rd), 64'd7);
    stall = 1'b0; flush = 1'b0;

    // Illegal select on the 3-source instance
    rd = 5'd4; sel = 2'd3;
    step("illegal");
    chk("illegal.b.err", 64'(b_err), 64'd1);
    chk("illegal.b.data", 64'(b_data), 64'd0);
    sel = 2'd0;
    step("legal_after");
    chk("sticky.b.err", 64'(b_err), 64'd1);
    valid = 1'b0; sel = 2'd3;
    step("bubble_illegal");
    flush = 1'b1;
    pulse_reset("rst_mid_flush");
    flush = 1'b0;
    chk("err_cleared", 64'(b_err), 64'd0);

    // Counter wrap: 17 valid loads
    valid = 1'b1; sel = 2'd2; rd = 5'd3;
    for (int i = 0; i < 17; i++) step("wrap");
    chk("wrap.b.cnt", 64'(b_cnt), 64'd1);
    chk("wrap.a.cnt", 64'(a_cnt), 64'd17);

    // Bubble still loads data
    valid = 1'b0; sel = 2'd1;
    step("bubble");

    // Forwarding flags
    valid = 1'b1; wr_en = 1'b1; rd = 5'd9; sel = 2'd1;
    step("fwd_load");
    rs1 = 5'd9; rs2 = 5'd0;
    #1;
    chk_fwd("fwd_rs1");
    rs2 = 5'd9;
    #1;
    chk_fwd("fwd_rs2");
    rs1 = 5'd0;
    #1;
    chk_fwd("fwd_rs1_x0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised writeback stage that succeeds the fixed 3:1 writeback mux.
- Selects one of NUM_SRC result sources by encoded select and registers the chosen value with rd address and write enable, forming the pipeline register into the register file.
- Adds stall hold, flush, x0 write suppression, a sticky illegal-select flag and a retire counter.
- Sits between the execute/memory stage and the register-file write port.

Parameters:
- DATA_W, 32, width of each source and of writeback data.
- NUM_SRC, 4, number of selectable sources; legal range 2..16.
- SEL_W, $clog2(NUM_SRC), select width (derived; do not override).
- RADDR_W, 5, register address width.
- CNT_W, 32, retire counter width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_src  input  NUM_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W]. Index 0 = J_WB (PC+4), 1 = ALU_WB, 2 = DMEM_WB, 3 = CSR/immediate.
- i_sel  input  SEL_W  source index.
- i_valid  input  1  upstream instruction valid.
- i_wr_en  input  1  upstream register write request.
- i_rd  input  RADDR_W  destination register.
- i_stall  input  1  hold stage contents.
- i_flush  input  1  kill stage contents.
- i_rs1, i_rs2  input  RADDR_W each  decode-stage source registers (forwarding).
- o_valid  output  1  registered valid.
- o_wr_en  output  1  registered register-file write enable.
- o_rd  output  RADDR_W  registered destination.
- o_wb_data  output  DATA_W  registered writeback data.
- o_sel_err  output  1  sticky illegal-select flag.
- o_retire_cnt  output  CNT_W  count of valid instructions captured.
- o_fwd_rs1, o_fwd_rs2  output  1 each  forward-hit flags.

Behaviour:
- Reset (asynchronous, i_rst_n = 0): all outputs and registers are 0 immediately and stay 0 while reset is held. Reset mid-stall or mid-flush discards the stage contents.
- Combinational pick:
  - sel_data = i_src slice i_sel when i_sel < NUM_SRC; otherwise 0.
  - There is no latch and no undefined output for any i_sel value.
- Latency: one cycle from inputs to o_* registers.
- Priority per rising edge: flush > stall > load.
  - Flush: o_valid <= 0 and o_wr_en <= 0. o_rd and o_wb_data keep their values. The counter does not increment. Flush wins over a simultaneous stall.
  - Stall (no flush): all o_* registers hold and the counter holds. An illegal select presented during stall is ignored.
  - Load (no stall, no flush):
    - o_valid <= i_valid.
    - o_rd <= i_rd.
    - o_wb_data <= sel_data.
    - o_wr_en <= i_valid & i_wr_en & (i_rd != 0) & legal_sel.
- x0 rule: a write to rd = 0 loads o_valid = 1 but o_wr_en = 0.
- Illegal select (i_sel >= NUM_SRC): o_sel_err is set when a load cycle has i_valid = 1 and i_sel is illegal.
  - o_sel_err stays 1 until reset.
  - When i_valid = 0, an illegal select is ignored.
- Retire counter: increments by 1 on each load cycle with i_valid = 1, including x0 writes and illegal selects. It wraps from 2^CNT_W-1 to 0.
- Bubbles: i_valid = 0 loads o_valid = 0 and o_wr_en = 0; data still loads.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - o_fwd_rs1 = o_valid & o_wr_en & (o_rd == i_rs1) & (i_rs1 != 0). o_fwd_rs2 is the same with i_rs2.
  - Combinational from the registered state; o_wb_data is the forwarded value.
- Not defined:
  - o_fwd_rs1 and o_fwd_rs2 are tied to 0.
  - i_rs1 and i_rs2 are unused.
  - All ports still exist in both builds, so the interface is identical.

Test Plan:
- Reset then select sweep:
  - Stimulus: i_src = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, i_valid = 1, i_wr_en = 1, i_rd = 5, i_sel = 0..3 in consecutive cycles.
  - Response: o_wb_data 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 one cycle later each; o_wr_en = 1; o_retire_cnt = 4.
- x0 suppression:
  - Stimulus: i_rd = 0, i_wr_en = 1, i_valid = 1, i_sel = 1.
  - Response: o_valid = 1, o_wr_en = 0, o_wb_data = 0xBBBB0001, counter +1.
- Stall then simultaneous flush:
  - Stimulus: load rd = 7 / ALU; assert i_stall for 3 cycles with changing inputs; then i_stall = 1 and i_flush = 1 together.
  - Response: outputs frozen at rd = 7 for 3 cycles, counter frozen; after flush o_valid = 0, o_wr_en = 0.
- Illegal select:
  - Stimulus: NUM_SRC = 3 build, i_sel = 3, i_valid = 1.
  - Response: o_wb_data = 0, o_wr_en = 0, o_sel_err = 1; o_sel_err stays 1 after later legal selects until i_rst_n is pulsed low.
- Counter wrap:
  - Stimulus: CNT_W = 4, 17 valid loads.
  - Response: o_retire_cnt = 1.
- Forwarding (WB_FWD_EN defined):
  - Stimulus: registered rd = 9, wr_en = 1; i_rs1 = 9, i_rs2 = 0; then i_rs2 = 9.
  - Response: o_fwd_rs1 = 1, o_fwd_rs2 = 0, then o_fwd_rs2 = 1. With the macro undefined, both stay 0.
